// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Provides the state encoding, the RV32I major-opcode constants, the mux-select
// encodings for alu_src_a/alu_src_b/alu_op/result_src, and a helper that reports
// whether an opcode is implemented by this core.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StInit     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluSub    = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  function automatic logic is_known_opcode(input logic [6:0] op);
    return (op == OpLoad) || (op == OpStore) || (op == OpRType) ||
           (op == OpIType) || (op == OpBranch) || (op == OpJal);
  endfunction

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// Control bus between the multicycle control FSM and the datapath.
// master: the control FSM (consumes opcode/funct3/zero, drives all enables/selects).
// slave : the datapath side (drives opcode/funct3/zero, consumes the controls).
// Signals: opcode[6:0], funct3[2:0], zero, pc_write, ior_d, mem_write, ir_write,
//          reg_write, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], result_src[1:0],
//          state_o[STATE_WIDTH-1:0], illegal_instr.
interface riscv_multicycle_control_if #(
  parameter int unsigned STATE_WIDTH = 4
);
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   zero;
  logic                   pc_write;
  logic                   ior_d;
  logic                   mem_write;
  logic                   ir_write;
  logic                   reg_write;
  logic [1:0]             alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             alu_op;
  logic [1:0]             result_src;
  logic [STATE_WIDTH-1:0] state_o;
  logic                   illegal_instr;

  modport master (
    input  opcode, funct3, zero,
    output pc_write, ior_d, mem_write, ir_write, reg_write,
    output alu_src_a, alu_src_b, alu_op, result_src, state_o, illegal_instr
  );

  modport slave (
    output opcode, funct3, zero,
    input  pc_write, ior_d, mem_write, ir_write, reg_write,
    input  alu_src_a, alu_src_b, alu_op, result_src, state_o, illegal_instr
  );
endinterface

// File: rtl/riscv_ctrl_wait_counter.sv
// Memory wait-state counter for the multicycle control FSM.
// Counts up while i_enable is high, saturating at MAX_COUNT; i_clear has priority.
// Ports: clk, reset (async active-low), i_clear, i_enable, o_done (count == MAX_COUNT).
module riscv_ctrl_wait_counter #(
  parameter int unsigned MAX_COUNT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);
  localparam int unsigned CntWidth = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_COUNT);

  logic [CntWidth-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_done) begin
      r_cnt <= r_cnt + CntWidth'(1);
    end
  end

  assign o_done = (r_cnt == CntMax);
endmodule

// File: rtl/riscv_multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences PC, IorD mux, unified memory, IR, regfile and ALU; all controls are
// Moore-decoded from the registered state (branch pc_write also looks at zero/funct3).
// Ports: clk, reset (async active-low), ctrl_bus (riscv_multicycle_control_if.master).
// Parameters: STATE_WIDTH (state_o width), MEM_WAIT_CYCLES (extra FETCH/MEMREAD cycles).
// Build option: define RISCV_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes
// (sticky illegal_instr, left only by reset); otherwise they execute as NOPs.
module riscv_multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STATE_WIDTH     = 4,
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_multicycle_control_if.master    ctrl_bus
);

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  localparam state_e UnknownOpNext = StTrap;
`else
  localparam state_e UnknownOpNext = StFetch;
`endif

  state_e     r_state;
  state_e     w_next;
  logic       w_wait_done;
  logic       w_wait_en;
  logic       w_wait_clr;

  logic       w_pc_write;
  logic       w_ior_d;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_result_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StInit;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_wait_en  = (r_state == StFetch) || (r_state == StMemRead);
  assign w_wait_clr = (w_next != r_state);

  riscv_ctrl_wait_counter #(
    .MAX_COUNT (MEM_WAIT_CYCLES)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wait_clr),
    .i_enable (w_wait_en),
    .o_done   (w_wait_done)
  );

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ior_d      = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = SrcAPc;
    w_alu_src_b  = SrcBRs2;
    w_alu_op     = AluAdd;
    w_result_src = ResAluOut;

    unique case (r_state)
      StInit: w_next = StFetch;
      StFetch: begin
        w_alu_src_b  = SrcBFour;
        w_result_src = ResAluResult;
        // IR and PC load only once the memory data is valid.
        if (w_wait_done) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = StDecode;
        end
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        w_alu_src_a = SrcAOldPc;
        w_alu_src_b = SrcBImm;
        if (ctrl_bus.opcode == OpLoad || ctrl_bus.opcode == OpStore) begin
          w_next = StMemAdr;
        end else if (ctrl_bus.opcode == OpRType) begin
          w_next = StExecR;
        end else if (ctrl_bus.opcode == OpIType) begin
          w_next = StExecI;
        end else if (ctrl_bus.opcode == OpBranch) begin
          w_next = StBranch;
        end else if (ctrl_bus.opcode == OpJal) begin
          w_next = StJal;
        end else begin
          w_next = UnknownOpNext;
        end
      end
      StMemAdr: begin
        w_alu_src_a = SrcARs1;
        w_alu_src_b = SrcBImm;
        w_next      = (ctrl_bus.opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        w_ior_d = 1'b1;
        if (w_wait_done) begin
          w_next = StMemWb;
        end
      end
      StMemWb: begin
        w_result_src = ResMemData;
        w_reg_write  = 1'b1;
        w_next       = StFetch;
      end
      StMemWrite: begin
        w_ior_d     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = StFetch;
      end
      StExecR: begin
        w_alu_src_a = SrcARs1;
        w_alu_op    = AluFunct;
        w_next      = StAluWb;
      end
      StExecI: begin
        w_alu_src_a = SrcARs1;
        w_alu_src_b = SrcBImm;
        w_alu_op    = AluFunct;
        w_next      = StAluWb;
      end
      StAluWb: begin
        w_reg_write = 1'b1;
        w_next      = StFetch;
      end
      StBranch: begin
        w_alu_src_a = SrcARs1;
        w_alu_op    = AluSub;
        // Only beq/bne are decoded; other funct3 values fall through as not taken.
        w_pc_write  = ((ctrl_bus.funct3 == F3Beq) &&  ctrl_bus.zero) ||
                      ((ctrl_bus.funct3 == F3Bne) && !ctrl_bus.zero);
        w_next      = StFetch;
      end
      StJal: begin
        w_alu_src_a = SrcAOldPc;
        w_alu_src_b = SrcBFour;
        w_pc_write  = 1'b1;
        w_next      = StAluWb;
      end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      StTrap: w_next = StTrap;
`endif
      default: w_next = StInit;
    endcase
  end

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Set on entry so the flag rises together with the TRAP state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_illegal <= 1'b0;
    end else if (w_next == StTrap) begin
      r_illegal <= 1'b1;
    end
  end

  assign ctrl_bus.illegal_instr = r_illegal;
`else
  assign ctrl_bus.illegal_instr = 1'b0;
`endif

  assign ctrl_bus.pc_write   = w_pc_write;
  assign ctrl_bus.ior_d      = w_ior_d;
  assign ctrl_bus.mem_write  = w_mem_write;
  assign ctrl_bus.ir_write   = w_ir_write;
  assign ctrl_bus.reg_write  = w_reg_write;
  assign ctrl_bus.alu_src_a  = w_alu_src_a;
  assign ctrl_bus.alu_src_b  = w_alu_src_b;
  assign ctrl_bus.alu_op     = w_alu_op;
  assign ctrl_bus.result_src = w_result_src;
  assign ctrl_bus.state_o    = STATE_WIDTH'(r_state);

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed self-checking bench for riscv_multicycle_control.
// dut0 uses MEM_WAIT_CYCLES=0, dut1 uses MEM_WAIT_CYCLES=2; both share clk/reset.
module tb_riscv_multicycle_control;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  riscv_multicycle_control_if #(.STATE_WIDTH(4)) bus0 ();
  riscv_multicycle_control_if #(.STATE_WIDTH(4)) bus1 ();

  riscv_multicycle_control #(
    .STATE_WIDTH     (4),
    .MEM_WAIT_CYCLES (0)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (bus0)
  );

  riscv_multicycle_control #(
    .STATE_WIDTH     (4),
    .MEM_WAIT_CYCLES (2)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-control vector {pc,ior,mw,irw,rw,a,b,op,res}.
  function automatic logic [12:0] ctl(input logic pc, input logic ior, input logic mw,
                                      input logic irw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic [1:0] res);
    return {pc, ior, mw, irw, rw, a, b, op, res};
  endfunction

  function automatic logic [12:0] obs0();
    return {bus0.pc_write, bus0.ior_d, bus0.mem_write, bus0.ir_write, bus0.reg_write,
            bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.result_src};
  endfunction

  function automatic logic [12:0] obs1();
    return {bus1.pc_write, bus1.ior_d, bus1.mem_write, bus1.ir_write, bus1.reg_write,
            bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.result_src};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus0.opcode = 7'b0000011;
    bus0.funct3 = 3'b000;
    bus0.zero   = 1'b0;
    bus1.opcode = 7'b0110011;
    bus1.funct3 = 3'b000;
    bus1.zero   = 1'b0;

    // 1. reset and first fetch
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus0.state_o), 32'd0);
    chk("rst_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00)));
    chk("rst_illegal", 32'(bus0.illegal_instr), 32'd0);
    reset = 1'b1;
    #1;
    chk("init_state", 32'(bus0.state_o), 32'd0);
    chk("init_ctl", 32'(obs0()), 32'd0);
    step();
    chk("fetch_state", 32'(bus0.state_o), 32'd1);
    chk("fetch_ctl", 32'(obs0()), 32'(ctl(1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10)));

    // 2. lw: 1,2,3,4,5 -> 1
    step();
    chk("lw_decode_state", 32'(bus0.state_o), 32'd2);
    chk("lw_decode_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00)));
    step();
    chk("lw_memadr_state", 32'(bus0.state_o), 32'd3);
    chk("lw_memadr_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00)));
    step();
    chk("lw_memread_state", 32'(bus0.state_o), 32'd4);
    chk("lw_memread_ctl", 32'(obs0()), 32'(ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00)));
    step();
    chk("lw_memwb_state", 32'(bus0.state_o), 32'd5);
    chk("lw_memwb_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01)));
    step();
    chk("lw_back_fetch", 32'(bus0.state_o), 32'd1);

    // 3. branch conditions
    bus0.opcode = 7'b1100011;
    bus0.funct3 = 3'b000;
    bus0.zero   = 1'b1;
    step();
    step();
    chk("br_state", 32'(bus0.state_o), 32'd10);
    chk("beq_taken_ctl", 32'(obs0()), 32'(ctl(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00)));
    bus0.zero = 1'b0;
    #1;
    chk("beq_not_taken", 32'(bus0.pc_write), 32'd0);
    bus0.funct3 = 3'b001;
    #1;
    chk("bne_taken", 32'(bus0.pc_write), 32'd1);
    bus0.zero = 1'b1;
    #1;
    chk("bne_not_taken", 32'(bus0.pc_write), 32'd0);
    bus0.funct3 = 3'b100;
    #1;
    chk("blt_unsupported", 32'(bus0.pc_write), 32'd0);
    step();
    chk("br_back_fetch", 32'(bus0.state_o), 32'd1);

    // R-type
    bus0.opcode = 7'b0110011;
    step();
    step();
    chk("r_exec_state", 32'(bus0.state_o), 32'd7);
    chk("r_exec_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00)));
    step();
    chk("r_aluwb_state", 32'(bus0.state_o), 32'd9);
    chk("r_aluwb_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00)));
    step();
    chk("r_back_fetch", 32'(bus0.state_o), 32'd1);

    // I-type
    bus0.opcode = 7'b0010011;
    step();
    step();
    chk("i_exec_state", 32'(bus0.state_o), 32'd8);
    chk("i_exec_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00)));
    step();
    chk("i_aluwb_state", 32'(bus0.state_o), 32'd9);
    step();
    chk("i_back_fetch", 32'(bus0.state_o), 32'd1);

    // JAL
    bus0.opcode = 7'b1101111;
    step();
    step();
    chk("jal_state", 32'(bus0.state_o), 32'd11);
    chk("jal_ctl", 32'(obs0()), 32'(ctl(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00)));
    step();
    chk("jal_aluwb_state", 32'(bus0.state_o), 32'd9);
    step();
    chk("jal_back_fetch", 32'(bus0.state_o), 32'd1);

    // 5. unknown opcode
    bus0.opcode = 7'b1111111;
    step();
    chk("ill_decode_ctl", 32'(obs0()), 32'(ctl(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00)));
    step();
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    chk("trap_state", 32'(bus0.state_o), 32'd12);
    chk("trap_ctl", 32'(obs0()), 32'd0);
    chk("trap_flag", 32'(bus0.illegal_instr), 32'd1);
    repeat (3) step();
    chk("trap_hold_state", 32'(bus0.state_o), 32'd12);
    chk("trap_hold_flag", 32'(bus0.illegal_instr), 32'd1);
    reset = 1'b0;
    #1;
    chk("trap_rst_flag", 32'(bus0.illegal_instr), 32'd0);
    chk("trap_rst_state", 32'(bus0.state_o), 32'd0);
    reset = 1'b1;
    step();
    chk("trap_rst_fetch", 32'(bus0.state_o), 32'd1);
`else
    chk("nop_back_fetch", 32'(bus0.state_o), 32'd1);
    chk("nop_flag", 32'(bus0.illegal_instr), 32'd0);
`endif

    // 6. sw with reset asserted in MEMWRITE
    bus0.opcode = 7'b0100011;
    step();
    step();
    chk("sw_memadr_state", 32'(bus0.state_o), 32'd3);
    step();
    chk("sw_memwrite_state", 32'(bus0.state_o), 32'd6);
    chk("sw_memwrite_ctl", 32'(obs0()), 32'(ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00)));
    reset = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(bus0.mem_write), 32'd0);
    chk("sw_rst_state", 32'(bus0.state_o), 32'd0);
    step();
    chk("sw_rst_held", 32'(bus0.state_o), 32'd0);
    reset = 1'b1;
    step();
    chk("sw_rel_fetch", 32'(bus0.state_o), 32'd1);
    chk("sw_rel_no_write", 32'(bus0.mem_write), 32'd0);

    // 4. MEM_WAIT_CYCLES=2 with sw, then lw
    reset = 1'b0;
    bus1.opcode = 7'b0100011;
    step();
    reset = 1'b1;
    step();
    chk("w_fetch0_state", 32'(bus1.state_o), 32'd1);
    chk("w_fetch0_ctl", 32'(obs1()), 32'(ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10)));
    step();
    chk("w_fetch1_ctl", 32'(obs1()), 32'(ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10)));
    step();
    chk("w_fetch2_ctl", 32'(obs1()), 32'(ctl(1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10)));
    step();
    chk("w_decode_state", 32'(bus1.state_o), 32'd2);
    step();
    chk("w_memadr_state", 32'(bus1.state_o), 32'd3);
    step();
    chk("w_memwrite_ctl", 32'(obs1()), 32'(ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00)));
    step();
    chk("w_after_sw_state", 32'(bus1.state_o), 32'd1);
    chk("w_after_sw_mw", 32'(bus1.mem_write), 32'd0);
    chk("w_after_sw_irw", 32'(bus1.ir_write), 32'd0);
    bus1.opcode = 7'b0000011;
    step();
    step();
    chk("w_lw_fetch2_irw", 32'(bus1.ir_write), 32'd1);
    step();
    step();
    step();
    chk("w_memread0", 32'(bus1.state_o), 32'd4);
    step();
    chk("w_memread1", 32'(bus1.state_o), 32'd4);
    step();
    chk("w_memread2", 32'(bus1.state_o), 32'd4);
    step();
    chk("w_memwb", 32'(bus1.state_o), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
